// File: rtl/mpc_rsp_reorder_buf_if.sv
// Bundle of allocation, out-of-order response and in-order release signals
// for the per-channel read-response reorder buffer.
interface mpc_rsp_reorder_buf_if #(
  parameter int NUM_CH    = 3,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 128
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ROB_W = $clog2(ROB_DEPTH);

  logic [NUM_CH-1:0]             alloc_valid_i;
  logic [NUM_CH-1:0]             alloc_ready_o;
  logic [NUM_CH*ROB_W-1:0]       alloc_id_o;
  logic                          rsp_valid_i;
  logic                          rsp_ready_o;
  logic [CH_W-1:0]               rsp_ch_i;
  logic [ROB_W-1:0]              rsp_id_i;
  logic [DATA_W-1:0]             rsp_data_i;
  logic [NUM_CH-1:0]             out_valid_o;
  logic [NUM_CH-1:0]             out_ready_i;
  logic [NUM_CH*DATA_W-1:0]      out_data_o;
  logic [NUM_CH*(ROB_W+1)-1:0]   count_o;
  logic                          err_o;

  modport master (
    output alloc_valid_i, rsp_valid_i, rsp_ch_i, rsp_id_i, rsp_data_i, out_ready_i,
    input  alloc_ready_o, alloc_id_o, rsp_ready_o, out_valid_o, out_data_o, count_o, err_o
  );

  modport slave (
    input  alloc_valid_i, rsp_valid_i, rsp_ch_i, rsp_id_i, rsp_data_i, out_ready_i,
    output alloc_ready_o, alloc_id_o, rsp_ready_o, out_valid_o, out_data_o, count_o, err_o
  );
endinterface

// File: rtl/mpc_rsp_reorder_buf.sv
// Per-channel reorder buffer: hands out rob IDs in order, absorbs tagged
// out-of-order responses, releases data per channel in allocation order.
module mpc_rsp_reorder_buf #(
  parameter int NUM_CH    = 3,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mpc_rsp_reorder_buf_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ROB_W = $clog2(ROB_DEPTH);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_ALLOC  = 2'd1,
    ST_FILLED = 2'd2
  } ent_st_e;

  ent_st_e           r_state [NUM_CH][ROB_DEPTH];
  logic [DATA_W-1:0] r_mem   [NUM_CH][ROB_DEPTH];
  logic [ROB_W:0]    r_head  [NUM_CH];
  logic [ROB_W:0]    r_tail  [NUM_CH];
  logic              r_err;

  logic [ROB_W:0]    w_count     [NUM_CH];
  logic [NUM_CH-1:0] w_alloc_rdy;
  logic [NUM_CH-1:0] w_alloc_fire;
  logic [NUM_CH-1:0] w_out_vld;
  logic [NUM_CH-1:0] w_deq;
  logic [NUM_CH-1:0] w_rsp_sel;
  logic              w_rsp_ch_ok;
  ent_st_e           w_rsp_tgt;
  logic              w_rsp_fill;
  logic              w_rsp_err;

  // Response decode: an out-of-range channel simply matches no channel.
  always_comb begin
    w_rsp_sel   = '0;
    w_rsp_ch_ok = 1'b0;
    w_rsp_tgt   = ST_FREE;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rsp_ch_i == CH_W'(c)) begin
        w_rsp_sel[c] = 1'b1;
        w_rsp_ch_ok  = 1'b1;
        w_rsp_tgt    = r_state[c][bus.rsp_id_i];
      end
    end
    w_rsp_fill = bus.rsp_valid_i && w_rsp_ch_ok && (w_rsp_tgt == ST_ALLOC);
    w_rsp_err  = bus.rsp_valid_i && !w_rsp_fill;
  end

  // Count never exceeds ROB_DEPTH, so its MSB alone flags "full".
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_count[c]      = r_tail[c] - r_head[c];
      w_alloc_rdy[c]  = !w_count[c][ROB_W];
      w_alloc_fire[c] = bus.alloc_valid_i[c] && w_alloc_rdy[c];
      w_out_vld[c]    = (r_state[c][r_head[c][ROB_W-1:0]] == ST_FILLED);
      w_deq[c]        = w_out_vld[c] && bus.out_ready_i[c];
    end
  end

  // Head data is gated by valid so the reset-time output reads as zero.
  always_comb begin
    bus.alloc_id_o = '0;
    bus.out_data_o = '0;
    bus.count_o    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.alloc_id_o[c*ROB_W +: ROB_W]       = r_tail[c][ROB_W-1:0];
      bus.count_o[c*(ROB_W+1) +: (ROB_W+1)]  = w_count[c];
      if (w_out_vld[c])
        bus.out_data_o[c*DATA_W +: DATA_W]   = r_mem[c][r_head[c][ROB_W-1:0]];
    end
  end

  assign bus.alloc_ready_o = w_alloc_rdy;
  assign bus.out_valid_o   = w_out_vld;
  assign bus.rsp_ready_o   = 1'b1;
  assign bus.err_o         = r_err;

  // Entry state / pointer update: alloc, fill and dequeue touch distinct slots.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_head[c] <= '0;
        r_tail[c] <= '0;
        for (int e = 0; e < ROB_DEPTH; e++)
          r_state[c][e] <= ST_FREE;
      end
    end else begin
      if (w_rsp_err)
        r_err <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_alloc_fire[c]) begin
          r_state[c][r_tail[c][ROB_W-1:0]] <= ST_ALLOC;
          r_tail[c] <= r_tail[c] + (ROB_W+1)'(1);
        end
        if (w_rsp_fill && w_rsp_sel[c])
          r_state[c][bus.rsp_id_i] <= ST_FILLED;
        if (w_deq[c]) begin
          r_state[c][r_head[c][ROB_W-1:0]] <= ST_FREE;
          r_head[c] <= r_head[c] + (ROB_W+1)'(1);
        end
      end
    end
  end

  // Data storage, deliberately outside reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rsp_fill && w_rsp_sel[c])
        r_mem[c][bus.rsp_id_i] <= bus.rsp_data_i;
    end
  end
endmodule

// File: tb/tb_mpc_rsp_reorder_buf.sv
// Directed bench for mpc_rsp_reorder_buf with NUM_CH=3, ROB_DEPTH=8, DATA_W=128.
module tb_mpc_rsp_reorder_buf;
  localparam int NUM_CH    = 3;
  localparam int ROB_DEPTH = 8;
  localparam int DATA_W    = 128;
  localparam int ROB_W     = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mpc_rsp_reorder_buf_if #(.NUM_CH(NUM_CH), .ROB_DEPTH(ROB_DEPTH), .DATA_W(DATA_W)) bus ();

  mpc_rsp_reorder_buf #(.NUM_CH(NUM_CH), .ROB_DEPTH(ROB_DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = '0;
    bus.rsp_valid_i   = 1'b0;
    bus.rsp_ch_i      = '0;
    bus.rsp_id_i      = '0;
    bus.rsp_data_i    = '0;
    bus.out_ready_i   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rsp(input int ch, input int id, input logic [DATA_W-1:0] d);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_ch_i    = 2'(ch);
    bus.rsp_id_i    = 3'(id);
    bus.rsp_data_i  = d;
  endtask

  function automatic logic [DATA_W-1:0] odata(input int c);
    return bus.out_data_o[c*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] cnt(input int c);
    return DATA_W'(bus.count_o[c*(ROB_W+1) +: (ROB_W+1)]);
  endfunction

  function automatic logic [DATA_W-1:0] aid(input int c);
    return DATA_W'(bus.alloc_id_o[c*ROB_W +: ROB_W]);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    tick();
    do_reset();

    // Reset state
    chk("rst_alloc_ready", DATA_W'(bus.alloc_ready_o), 128'h7);
    chk("rst_alloc_id",    DATA_W'(bus.alloc_id_o),    128'h0);
    chk("rst_out_valid",   DATA_W'(bus.out_valid_o),   128'h0);
    chk("rst_out_data",    DATA_W'(bus.out_data_o),    128'h0);
    chk("rst_count",       DATA_W'(bus.count_o),       128'h0);
    chk("rst_err",         DATA_W'(bus.err_o),         128'h0);
    chk("rst_rsp_ready",   DATA_W'(bus.rsp_ready_o),   128'h1);

    // In-order on ch0
    bus.alloc_valid_i = 3'b001;
    for (int i = 0; i < 3; i++) begin
      chk("io_alloc_id", aid(0), DATA_W'(i));
      tick();
    end
    bus.alloc_valid_i = '0;
    chk("io_count3", cnt(0), 128'd3);
    chk("io_novalid", DATA_W'(bus.out_valid_o[0]), 128'h0);
    bus.out_ready_i = 3'b111;
    rsp(0, 0, 128'hA);  tick();
    chk("io_vA", DATA_W'(bus.out_valid_o[0]), 128'h1);
    chk("io_dA", odata(0), 128'hA);
    rsp(0, 1, 128'hB);  tick();
    chk("io_vB", DATA_W'(bus.out_valid_o[0]), 128'h1);
    chk("io_dB", odata(0), 128'hB);
    rsp(0, 2, 128'hC);  tick();
    chk("io_vC", DATA_W'(bus.out_valid_o[0]), 128'h1);
    chk("io_dC", odata(0), 128'hC);
    bus.rsp_valid_i = 1'b0; tick();
    chk("io_vdone", DATA_W'(bus.out_valid_o[0]), 128'h0);
    chk("io_count0", cnt(0), 128'd0);
    chk("io_noerr", DATA_W'(bus.err_o), 128'h0);

    // Reverse order on ch1
    do_reset();
    bus.alloc_valid_i = 3'b010;
    repeat (4) tick();
    bus.alloc_valid_i = '0;
    bus.out_ready_i   = 3'b111;
    for (int i = 3; i >= 1; i--) begin
      rsp(1, i, 128'hD0 + DATA_W'(i)); tick();
      chk("rv_hold", DATA_W'(bus.out_valid_o[1]), 128'h0);
    end
    rsp(1, 0, 128'hD0); tick();
    bus.rsp_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rv_valid", DATA_W'(bus.out_valid_o[1]), 128'h1);
      chk("rv_data",  odata(1), 128'hD0 + DATA_W'(i));
      tick();
    end
    chk("rv_vdone", DATA_W'(bus.out_valid_o[1]), 128'h0);
    chk("rv_count", cnt(1), 128'd0);

    // Full / wrap on ch2
    do_reset();
    bus.alloc_valid_i = 3'b100;
    repeat (8) tick();
    chk("fw_ready0", DATA_W'(bus.alloc_ready_o[2]), 128'h0);
    chk("fw_count8", cnt(2), 128'd8);
    tick();
    chk("fw_count_stay", cnt(2), 128'd8);
    bus.alloc_valid_i = '0;
    rsp(2, 0, 128'hE0); tick();
    bus.rsp_valid_i = 1'b0;
    chk("fw_v0", DATA_W'(bus.out_valid_o[2]), 128'h1);
    bus.out_ready_i   = 3'b100;
    bus.alloc_valid_i = 3'b100;
    tick();
    chk("fw_nopass", cnt(2), 128'd7);
    chk("fw_ready1", DATA_W'(bus.alloc_ready_o[2]), 128'h1);
    chk("fw_wrap_id", aid(2), 128'd0);
    bus.alloc_valid_i = '0;
    bus.out_ready_i   = '0;
    rsp(2, 1, 128'hE1); tick();
    bus.rsp_valid_i = 1'b0;
    chk("fw_d1", odata(2), 128'hE1);
    bus.out_ready_i   = 3'b100;
    bus.alloc_valid_i = 3'b100;
    tick();
    bus.alloc_valid_i = '0;
    bus.out_ready_i   = '0;
    chk("fw_alloc_deq_cnt", cnt(2), 128'd7);
    chk("fw_alloc_id1", aid(2), 128'd1);
    chk("fw_head_alloc", DATA_W'(bus.out_valid_o[2]), 128'h0);

    // Backpressure on ch0
    do_reset();
    bus.alloc_valid_i = 3'b001; tick();
    bus.alloc_valid_i = '0;
    rsp(0, 0, 128'hDEAD); tick();
    bus.rsp_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", DATA_W'(bus.out_valid_o[0]), 128'h1);
      chk("bp_data",  odata(0), 128'hDEAD);
      tick();
    end
    chk("bp_count1", cnt(0), 128'd1);
    bus.out_ready_i = 3'b001; tick();
    chk("bp_deq", DATA_W'(bus.out_valid_o[0]), 128'h0);
    chk("bp_count0", cnt(0), 128'd0);

    // Response to a FREE entry
    do_reset();
    rsp(0, 5, 128'h55); tick();
    bus.rsp_valid_i = 1'b0;
    chk("ef_err", DATA_W'(bus.err_o), 128'h1);
    chk("ef_noout", DATA_W'(bus.out_valid_o), 128'h0);
    repeat (3) tick();
    chk("ef_sticky", DATA_W'(bus.err_o), 128'h1);

    // Duplicate response to a FILLED entry
    do_reset();
    bus.alloc_valid_i = 3'b001; tick();
    bus.alloc_valid_i = '0;
    rsp(0, 0, 128'hAAAA); tick();
    chk("ed_noerr", DATA_W'(bus.err_o), 128'h0);
    rsp(0, 0, 128'hBBBB); tick();
    bus.rsp_valid_i = 1'b0;
    chk("ed_err", DATA_W'(bus.err_o), 128'h1);
    chk("ed_keep", odata(0), 128'hAAAA);

    // Out-of-range channel
    do_reset();
    rsp(3, 0, 128'h33); tick();
    bus.rsp_valid_i = 1'b0;
    chk("ec_err", DATA_W'(bus.err_o), 128'h1);

    // Response to the slot being allocated in the same cycle
    do_reset();
    bus.alloc_valid_i = 3'b001;
    rsp(0, 0, 128'h77); tick();
    bus.alloc_valid_i = '0;
    bus.rsp_valid_i   = 1'b0;
    chk("ea_err", DATA_W'(bus.err_o), 128'h1);
    chk("ea_noout", DATA_W'(bus.out_valid_o[0]), 128'h0);
    chk("ea_count", cnt(0), 128'd1);

    // Reset in the middle of activity
    do_reset();
    bus.alloc_valid_i = 3'b010;
    repeat (4) tick();
    bus.alloc_valid_i = '0;
    rsp(1, 0, 128'h10); tick();
    rsp(1, 1, 128'h11); tick();
    rsp(1, 7, 128'h17); tick();
    bus.rsp_valid_i = 1'b0;
    chk("mr_pre_err", DATA_W'(bus.err_o), 128'h1);
    chk("mr_pre_cnt", cnt(1), 128'd4);
    bus.alloc_valid_i = 3'b111;
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("mr_count",       DATA_W'(bus.count_o),       128'h0);
    chk("mr_alloc_ready", DATA_W'(bus.alloc_ready_o), 128'h7);
    chk("mr_alloc_id",    DATA_W'(bus.alloc_id_o),    128'h0);
    chk("mr_out_valid",   DATA_W'(bus.out_valid_o),   128'h0);
    chk("mr_out_data",    DATA_W'(bus.out_data_o),    128'h0);
    chk("mr_err",         DATA_W'(bus.err_o),         128'h0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
